// File: rtl/dec_pkg.sv
// Shared types and reference decode for the 3-to-8 one-hot decoder.
// The optional shift cross-check is enabled by DEC_SHIFT_XCHECK_EN.
package dec_pkg;

    localparam int DEC_IN_W  = 3;
    localparam int DEC_OUT_W = 8;

    typedef logic [DEC_IN_W-1:0]  dec_idx_t;
    typedef logic [DEC_OUT_W-1:0] dec_onehot_t;

    function automatic dec_onehot_t onehot_of(input dec_idx_t idx, input logic en);
        onehot_of = en ? (dec_onehot_t'(1) << idx) : '0;
    endfunction

endpackage

// File: rtl/dec_onehot_core.sv
// Purely combinational case-based binary-to-one-hot decode.
// Unknown or disabled inputs fall into the default arms and produce all zeros.
module dec_onehot_core
    import dec_pkg::*;
#(
    parameter  int IN_W  = DEC_IN_W,
    localparam int OUT_W = 2 ** IN_W
) (
    input  logic             en,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out
);

    always_comb begin
        out = '0;
        case (en)
            1'b1: begin
                // Exact case matching means an X/Z index hits no arm.
                for (int i = 0; i < OUT_W; i++) begin
                    case (in)
                        IN_W'(i): out[i] = 1'b1;
                        default:  out[i] = 1'b0;
                    endcase
                end
            end
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/dec3to8_case.sv
// Enable-gated one-hot decoder with combinational and registered outputs.
// Define DEC_SHIFT_XCHECK_EN to add a shift-based decode cross-check and xchk_err.
module dec3to8_case
    import dec_pkg::*;
#(
    parameter  int IN_W  = DEC_IN_W,
    localparam int OUT_W = 2 ** IN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
    output logic [OUT_W-1:0] out_q,
    output logic             out_vld,
    output logic [IN_W-1:0]  out_idx_q
`ifdef DEC_SHIFT_XCHECK_EN
    ,
    output logic             xchk_err
`endif
);

    if (IN_W < 1 || IN_W > 5) begin : g_bad_in_w
        $error("dec3to8_case: IN_W must be in 1..5");
    end

    logic [OUT_W-1:0] w_out;
    logic [OUT_W-1:0] r_out_q;
    logic             r_out_vld;
    logic [IN_W-1:0]  r_out_idx_q;

    dec_onehot_core #(
        .IN_W (IN_W)
    ) u_core (
        .en  (en),
        .in  (in),
        .out (w_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_q     <= '0;
            r_out_vld   <= 1'b0;
            r_out_idx_q <= '0;
        end else begin
            r_out_q   <= w_out;
            r_out_vld <= en;
            if (en) begin
                r_out_idx_q <= in;
            end
        end
    end

    assign out       = w_out;
    assign out_q     = r_out_q;
    assign out_vld   = r_out_vld;
    assign out_idx_q = r_out_idx_q;

`ifdef DEC_SHIFT_XCHECK_EN
    logic [OUT_W-1:0] w_shift;
    logic             r_xchk_err;

    if (IN_W == DEC_IN_W) begin : g_shift_pkg
        assign w_shift = OUT_W'(onehot_of(in, en));
    end else begin : g_shift_gen
        assign w_shift = en ? (OUT_W'(1) << in) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xchk_err <= 1'b0;
        end else begin
            r_xchk_err <= (w_out != w_shift);
        end
    end

    assign xchk_err = r_xchk_err;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && (w_out != w_shift)) begin
            $error("dec3to8_case: case decode %b differs from shift decode %b", w_out, w_shift);
        end
    end
`endif
`endif

endmodule

// File: tb/tb_dec3to8_case.sv
// Self-checking bench for dec3to8_case against a behavioural one-hot model.
// Also exercises xchk_err when built with DEC_SHIFT_XCHECK_EN.
module tb_dec3to8_case;
    import dec_pkg::*;

    logic        clk;
    logic        rst;
    logic        en;
    logic [2:0]  in_s;
    logic [7:0]  out;
    logic [7:0]  out_q;
    logic        out_vld;
    logic [2:0]  out_idx_q;
`ifdef DEC_SHIFT_XCHECK_EN
    logic        xchk_err;
`endif

    int checks = 0;
    int errors = 0;

    // Expected registered state, advanced once per rising edge.
    logic [7:0] m_q;
    logic       m_vld;
    logic [2:0] m_idx;

    dec3to8_case #(
        .IN_W (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in        (in_s),
        .out       (out),
        .out_q     (out_q),
        .out_vld   (out_vld),
        .out_idx_q (out_idx_q)
`ifdef DEC_SHIFT_XCHECK_EN
        ,
        .xchk_err  (xchk_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] model_dec(input logic e, input logic [2:0] i);
        if (e !== 1'b1 || $isunknown(i)) return 8'h00;
        return 8'(2 ** int'(i));
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_q   = '0;
            m_vld = 1'b0;
            m_idx = '0;
        end else begin
            m_q   = model_dec(en, in_s);
            m_vld = (en === 1'b1);
            if (en === 1'b1) m_idx = in_s;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; in_s = 3'd0;
        #2;
        checks++;
        if (out_q !== 8'h00 || out_vld !== 1'b0 || out_idx_q !== 3'd0) begin
            errors++;
            $display("FAIL reset_async got q=%b vld=%b idx=%0d want 0/0/0", out_q, out_vld, out_idx_q);
        end
        en = 1'b1; in_s = 3'd4;
        tick();
        checks++;
        if (out_q !== 8'h00 || out_vld !== 1'b0 || out_idx_q !== 3'd0) begin
            errors++;
            $display("FAIL reset_hold got q=%b vld=%b idx=%0d want 0/0/0", out_q, out_vld, out_idx_q);
        end
        checks++;
        if (out !== 8'b0001_0000) begin
            errors++;
            $display("FAIL reset_comb got %b want 00010000", out);
        end
        rst = 1'b0; en = 1'b0; in_s = 3'd0;
        tick();
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 8; i++) begin
            en = 1'b1; in_s = 3'(i);
            #1;
            checks++;
            if (out !== model_dec(1'b1, 3'(i))) begin
                errors++;
                $display("FAIL sweep_comb in=%0d got %b want %b", i, out, model_dec(1'b1, 3'(i)));
            end
            tick();
            checks++;
            if (out_q !== m_q || out_vld !== 1'b1 || out_idx_q !== 3'(i)) begin
                errors++;
                $display("FAIL sweep_reg in=%0d got q=%b vld=%b idx=%0d want q=%b vld=1 idx=%0d",
                         i, out_q, out_vld, out_idx_q, m_q, i);
            end
        end
    endtask

    task automatic test_disabled();
        for (int i = 0; i < 8; i++) begin
            en = 1'b0; in_s = 3'(i);
            #1;
            checks++;
            if (out !== 8'h00) begin
                errors++;
                $display("FAIL idle_comb in=%0d got %b want 00000000", i, out);
            end
            tick();
            checks++;
            if (out_q !== 8'h00 || out_vld !== 1'b0 || out_idx_q !== m_idx) begin
                errors++;
                $display("FAIL idle_reg in=%0d got q=%b vld=%b idx=%0d want q=0 vld=0 idx=%0d",
                         i, out_q, out_vld, out_idx_q, m_idx);
            end
        end
    endtask

    task automatic test_midstream_reset();
        en = 1'b1; in_s = 3'd6;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_q !== 8'h00 || out_vld !== 1'b0 || out_idx_q !== 3'd0) begin
            errors++;
            $display("FAIL mid_rst_async got q=%b vld=%b idx=%0d want 0/0/0", out_q, out_vld, out_idx_q);
        end
        checks++;
        if (out !== 8'b0100_0000) begin
            errors++;
            $display("FAIL mid_rst_comb got %b want 01000000", out);
        end
        tick();
        checks++;
        if (out_q !== 8'h00 || out_vld !== 1'b0 || out !== 8'b0100_0000) begin
            errors++;
            $display("FAIL mid_rst_hold got q=%b vld=%b out=%b want q=0 vld=0 out=01000000", out_q, out_vld, out);
        end
        #3;
        rst = 1'b0;
        tick();
        checks++;
        if (out_q !== 8'b0100_0000 || out_vld !== 1'b1 || out_idx_q !== 3'd6 || out_q !== m_q) begin
            errors++;
            $display("FAIL mid_rst_release got q=%b vld=%b idx=%0d want q=01000000 vld=1 idx=6", out_q, out_vld, out_idx_q);
        end
    endtask

    task automatic test_alternate();
        for (int c = 0; c < 8; c++) begin
            en = (c % 2 == 0); in_s = 3'd2;
            tick();
            checks++;
            if (out_q !== ((c % 2 == 0) ? 8'b0000_0100 : 8'h00) || out_vld !== (c % 2 == 0)) begin
                errors++;
                $display("FAIL alternate c=%0d got q=%b vld=%b want q=%b", c, out_q, out_vld,
                         (c % 2 == 0) ? 8'b0000_0100 : 8'h00);
            end
        end
    endtask

    task automatic test_unknown_index();
        en = 1'b1; in_s = 3'bx;
        #1;
        checks++;
        if ($isunknown(out) || out !== model_dec(en, in_s)) begin
            errors++;
            $display("FAIL xin_comb got %b want %b", out, model_dec(en, in_s));
        end
        tick();
        checks++;
        if ($isunknown(out_q) || out_q !== m_q) begin
            errors++;
            $display("FAIL xin_reg got %b want %b", out_q, m_q);
        end
        in_s = 3'd0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            en = 1'($urandom_range(0, 3) != 0);
            in_s = 3'($urandom_range(0, 7));
            #1;
            checks++;
            if (out !== model_dec(en, in_s)) begin
                errors++;
                $display("FAIL rand_comb c=%0d en=%b in=%0d got %b want %b", c, en, in_s, out, model_dec(en, in_s));
            end
            tick();
            checks++;
            if (out_q !== m_q || out_vld !== m_vld || out_idx_q !== m_idx) begin
                errors++;
                $display("FAIL rand_reg c=%0d got q=%b vld=%b idx=%0d want q=%b vld=%b idx=%0d",
                         c, out_q, out_vld, out_idx_q, m_q, m_vld, m_idx);
            end
            checks++;
            if ($countones(out) > 1 || (($countones(out_q) == 1) != (out_vld == 1'b1))) begin
                errors++;
                $display("FAIL rand_invariant c=%0d got out=%b q=%b vld=%b want popcount(out)<=1 and popcount(q)==vld",
                         c, out, out_q, out_vld);
            end
        end
    endtask

`ifdef DEC_SHIFT_XCHECK_EN
    task automatic test_xcheck();
        for (int e = 0; e < 2; e++) begin
            for (int i = 0; i < 8; i++) begin
                en = 1'(e); in_s = 3'(i);
                tick();
                checks++;
                if (xchk_err !== 1'b0) begin
                    errors++;
                    $display("FAIL xcheck en=%0d in=%0d got %b want 0", e, i, xchk_err);
                end
            end
        end
    endtask
`endif

    initial begin
        m_q = '0; m_vld = 1'b0; m_idx = '0;
        test_reset();
        test_sweep();
        test_disabled();
        test_midstream_reset();
        test_alternate();
        test_unknown_index();
        test_random();
`ifdef DEC_SHIFT_XCHECK_EN
        test_xcheck();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
